// File: rtl/debounce_fsm_pkg.sv
// Shared helpers for the switch debouncer.
package debounce_fsm_pkg;

    // Width of a down-counter that must hold values 0 .. cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit.
module sync_chain #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Switch debouncer: synchronise sw, then require a stable run before the level changes.
module debounce_fsm
    import debounce_fsm_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 2_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic settling
);

    localparam int unsigned    CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

    // Gray-ordered so every legal transition flips exactly one bit.
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b11,
        WAIT0 = 2'b10
    } state_e;

    logic             sw_s;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_level_q;
    logic             db_level_d;
    logic             settling_q;
    logic             settling_d;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (sw_s)
    );

    // Next-state, hold counter and Moore output decode of the next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        db_level_d = 1'b0;
        settling_d = 1'b0;

        case (state_q)
            ZERO: begin
                if (sw_s) begin
                    state_d = WAIT1;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_d = ZERO;
                end else if (cnt_q == '0) begin
                    state_d = ONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_d = WAIT0;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_d = ONE;
                end else if (cnt_q == '0) begin
                    state_d = ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ZERO;
            end
        endcase

        db_level_d = (state_d == ONE)   || (state_d == WAIT0);
        settling_d = (state_d == WAIT1) || (state_d == WAIT0);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ZERO;
            cnt_q      <= '0;
            db_level_q <= 1'b0;
            settling_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level_q <= db_level_d;
            settling_q <= settling_d;
        end
    end

    assign db_level = db_level_q;
    assign settling = settling_q;

endmodule
